// File: rtl/adder_pkg.sv
// Shared definitions for the limb-serial wide adder and its 16-bit limb adder.
package adder_pkg;

    localparam int LIMB_W    = 16;
    localparam int MAX_LIMBS = 16;
    localparam int MAX_W     = LIMB_W * MAX_LIMBS;
    localparam int K_W       = 4;

    typedef enum logic [1:0] {
        WA_IDLE = 2'd0,
        WA_RUN  = 2'd1,
        WA_DONE = 2'd2
    } wa_state_t;

    // Returns limb k of a (zero-extended) wide vector.
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [MAX_W-1:0] vec,
                                                   input logic [K_W-1:0]   k);
        limb_sel = vec[k * LIMB_W +: LIMB_W];
    endfunction

endpackage

// File: rtl/adder.sv
// 16-bit combinational Kogge-Stone prefix adder used as the shared limb adder.
module adder (
    output logic        cout,
    output logic [15:0] sum,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin
);

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [16:0] c_s;

    // Generate/propagate prefix tree, then carries and sum bits.
    always_comb begin : prefix_tree
        logic [15:0] gg;
        logic [15:0] pp;
        g_s = a & b;
        p_s = a ^ b;
        gg  = g_s;
        pp  = p_s;
        for (int lvl = 0; lvl < 4; lvl++) begin
            // Walk downward so lower indices still hold the previous level.
            for (int i = 15; i >= (1 << lvl); i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
                pp[i] = pp[i] & pp[i - (1 << lvl)];
            end
        end
        c_s[0] = cin;
        for (int i = 0; i < 16; i++) begin
            c_s[i+1] = gg[i] | (pp[i] & cin);
        end
        sum  = p_s ^ c_s[15:0];
        cout = c_s[16];
    end

endmodule

// File: rtl/wide_add_seq.sv
// Limb-serial W-bit adder/subtractor: one 16-bit limb per cycle through a
// single shared prefix adder, with the limb carry held in a register.
import adder_pkg::*;

module wide_add_seq #(
    parameter int NLIMBS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LIMB_W*NLIMBS-1:0] in_a,
    input  logic [LIMB_W*NLIMBS-1:0] in_b,
    input  logic                     in_cin,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LIMB_W*NLIMBS-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int W  = LIMB_W * NLIMBS;
    localparam int CW = $clog2(NLIMBS);
    localparam logic [CW-1:0] K_LAST = CW'(NLIMBS - 1);

    wa_state_t         state_r;
    wa_state_t         state_nxt_s;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              sub_r;
    logic              carry_r;
    logic [CW-1:0]     k_r;
    logic [W-1:0]      result_r;
    logic [W-1:0]      result_nxt_s;
    logic [W-1:0]      out_sum_r;
    logic              out_cout_r;
    logic              last_s;

    logic [LIMB_W-1:0] add_a_s;
    logic [LIMB_W-1:0] add_b_s;
    logic [LIMB_W-1:0] b_limb_s;
    logic              add_cin_s;
    logic [LIMB_W-1:0] add_sum_s;
    logic              add_cout_s;

    adder u_adder (
        .cout (add_cout_s),
        .sum  (add_sum_s),
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s)
    );

    // Select limb k of the operands; subtraction inverts B (borrow folded into carry).
    always_comb begin
        add_a_s   = limb_sel(MAX_W'(a_r), K_W'(k_r));
        b_limb_s  = limb_sel(MAX_W'(b_r), K_W'(k_r));
        add_b_s   = sub_r ? ~b_limb_s : b_limb_s;
        add_cin_s = carry_r;
        last_s    = (state_r == WA_RUN) && (k_r == K_LAST);
    end

    // Result vector with limb k replaced by the current adder sum.
    always_comb begin
        result_nxt_s = result_r;
        result_nxt_s[k_r * LIMB_W +: LIMB_W] = add_sum_s;
    end

    // Next-state logic for the request/run/done sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WA_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = WA_RUN;
                end else begin
                    state_nxt_s = WA_IDLE;
                end
            end
            WA_RUN: begin
                if (k_r == K_LAST) begin
                    state_nxt_s = WA_DONE;
                end else begin
                    state_nxt_s = WA_RUN;
                end
            end
            WA_DONE: begin
                if (out_ready) begin
                    state_nxt_s = WA_IDLE;
                end else begin
                    state_nxt_s = WA_DONE;
                end
            end
            default: state_nxt_s = WA_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WA_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, per-limb accumulation and final result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            sub_r      <= 1'b0;
            carry_r    <= 1'b0;
            k_r        <= {CW{1'b0}};
            result_r   <= {W{1'b0}};
            out_sum_r  <= {W{1'b0}};
            out_cout_r <= 1'b0;
        end else begin
            case (state_r)
                WA_IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        sub_r   <= in_sub;
                        carry_r <= in_sub ? ~in_cin : in_cin;
                        k_r     <= {CW{1'b0}};
                    end
                end
                WA_RUN: begin
                    result_r <= result_nxt_s;
                    carry_r  <= add_cout_s;
                    k_r      <= k_r + CW'(1);
                    // Published outputs only change when the last limb lands.
                    if (last_s) begin
                        out_sum_r  <= result_nxt_s;
                        out_cout_r <= add_cout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_r == WA_IDLE);
    assign out_valid = (state_r == WA_DONE);
    assign busy      = (state_r == WA_RUN);
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (NLIMBS=4 and NLIMBS=2 instances).
module tb_wide_add_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // NLIMBS = 4 instance
    logic        v4, rdy4, cin4, sub4, ov4, ordy4, cout4, busy4;
    logic [63:0] a4, b4, sum4;
    // NLIMBS = 2 instance
    logic        v2, rdy2, cin2, sub2, ov2, ordy2, cout2, busy2;
    logic [31:0] a2, b2, sum2;

    wide_add_seq #(.NLIMBS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .in_cin(cin4), .in_sub(sub4),
        .out_valid(ov4), .out_ready(ordy4), .out_sum(sum4),
        .out_cout(cout4), .busy(busy4)
    );

    wide_add_seq #(.NLIMBS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .in_cin(cin2), .in_sub(sub2),
        .out_valid(ov2), .out_ready(ordy2), .out_sum(sum2),
        .out_cout(cout2), .busy(busy2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: {cout, sum} of (A +/- B +/- cin) on w-bit operands.
    function automatic logic [64:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic cin, input logic sub, input int w);
        logic [64:0] mask;
        logic [64:0] t;
        logic        c;
        mask = (65'd1 << w) - 65'd1;
        if (!sub) begin
            t = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            c = t[w];
        end else begin
            t = {1'b0, a} - {1'b0, b} - {64'd0, cin};
            c = ({1'b0, a} >= ({1'b0, b} + {64'd0, cin}));
        end
        return {c, t[63:0] & mask[63:0]};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return {32'd0, $urandom_range(0, 15)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        int n;
        n = 0;
        while (!rdy4 && n < 40) begin
            tick();
            n++;
        end
        if (!rdy4) check_eq("start4_timeout", 64'(rdy4), 64'd1);
        v4 = 1'b1; a4 = a; b4 = b; cin4 = c; sub4 = s;
        tick();
        v4 = 1'b0;
    endtask

    task automatic wait4(output int n);
        n = 1;
        while (!ov4 && n < 40) begin
            tick();
            n++;
        end
        if (!ov4) check_eq("valid4_timeout", 64'(ov4), 64'd1);
    endtask

    task automatic drain4(input int stall, input logic [64:0] exp, input string tag);
        check_eq({tag, "_sum"}, sum4, exp[63:0]);
        check_eq({tag, "_cout"}, 64'(cout4), 64'(exp[64]));
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq({tag, "_hold_sum"}, sum4, exp[63:0]);
            check_eq({tag, "_hold_flags"}, 64'({ov4, rdy4, cout4}), 64'({2'b10, exp[64]}));
        end
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        check_eq({tag, "_after_hs"}, 64'({ov4, rdy4}), 64'(2'b01));
    endtask

    task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input int stall);
        logic [64:0] exp;
        int n;
        exp = ref_model(64'(a), 64'(b), c, s, 32);
        n = 0;
        while (!rdy2 && n < 40) begin
            tick();
            n++;
        end
        if (!rdy2) check_eq("start2_timeout", 64'(rdy2), 64'd1);
        v2 = 1'b1; a2 = a; b2 = b; cin2 = c; sub2 = s;
        tick();
        v2 = 1'b0;
        n = 1;
        while (!ov2 && n < 40) begin
            tick();
            n++;
        end
        check_eq("n2_latency", 64'(n), 64'd3);
        check_eq("n2_sum", 64'(sum2), exp[63:0]);
        check_eq("n2_cout", 64'(cout2), 64'(exp[64]));
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("n2_hold", 64'({ov2, rdy2, sum2}), {30'd0, 2'b10, exp[31:0]});
        end
        ordy2 = 1'b1;
        tick();
        ordy2 = 1'b0;
    endtask

    initial begin : main
        int n;
        logic [63:0] ra, rb;
        logic rc, rs;
        logic [63:0] qa[4], qb[4];
        logic        qc[4], qs[4];
        logic [64:0] qe[4];
        int got, last, idx;
        logic pend;

        {v4, cin4, sub4, ordy4, a4, b4} = '0;
        {v2, cin2, sub2, ordy2, a2, b2} = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_flags", 64'({rdy4, ov4, busy4, cout4}), 64'(4'b1000));
        check_eq("reset_sum", sum4, 64'd0);
        rst_n = 1'b1;
        tick();

        // Full carry ripple through all limbs, with exact latency.
        start4({64{1'b1}}, 64'd0, 1'b1, 1'b0);
        check_eq("ripple_busy", 64'({busy4, rdy4}), 64'(2'b10));
        wait4(n);
        check_eq("ripple_latency", 64'(n), 64'd5);
        drain4(0, {1'b1, 64'd0}, "ripple");

        // Subtract with and without borrow.
        start4(64'd5, 64'd7, 1'b0, 1'b1);
        wait4(n);
        drain4(0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, "sub_borrow");
        start4(64'd7, 64'd5, 1'b0, 1'b1);
        wait4(n);
        drain4(0, {1'b1, 64'd2}, "sub_noborrow");

        // Backpressure: hold DONE for 10 cycles with a new request pending.
        start4(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        wait4(n);
        v4 = 1'b1; a4 = 64'hDEAD_BEEF_0000_FFFF; b4 = 64'h0000_0001_FFFF_0001; cin4 = 1'b1; sub4 = 1'b1;
        drain4(10, ref_model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 64), "bp");
        tick();
        v4 = 1'b0;
        wait4(n);
        check_eq("bp_next_latency", 64'(n), 64'd5);
        drain4(0, ref_model(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, 1'b1, 64), "bp_next");

        // Reset in the middle of RUN discards the operation.
        start4({64{1'b1}}, {64{1'b1}}, 1'b1, 1'b0);
        tick();
        check_eq("midrst_busy", 64'(busy4), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_flags", 64'({rdy4, ov4, busy4, cout4}), 64'(4'b1000));
        check_eq("midrst_sum", sum4, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("midrst_idle", 64'({rdy4, ov4}), 64'(2'b10));
        start4(64'd1, 64'd1, 1'b0, 1'b0);
        wait4(n);
        check_eq("after_rst_latency", 64'(n), 64'd5);
        drain4(0, {1'b0, 64'd2}, "after_rst");

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 4; i++) begin
            qa[i] = rnd64(); qb[i] = rnd64();
            qc[i] = 1'($urandom_range(0, 1)); qs[i] = 1'($urandom_range(0, 1));
            qe[i] = ref_model(qa[i], qb[i], qc[i], qs[i], 64);
        end
        idx = 0; got = 0; last = 0;
        v4 = 1'b1; a4 = qa[0]; b4 = qb[0]; cin4 = qc[0]; sub4 = qs[0];
        ordy4 = 1'b1;
        pend = rdy4;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            tick();
            if (pend) begin
                idx++;
                if (idx < 4) begin
                    a4 = qa[idx]; b4 = qb[idx]; cin4 = qc[idx]; sub4 = qs[idx];
                end else begin
                    v4 = 1'b0;
                end
                pend = 1'b0;
            end
            if (ov4) begin
                check_eq("b2b_sum", sum4, qe[got][63:0]);
                check_eq("b2b_cout", 64'(cout4), 64'(qe[got][64]));
                if (got > 0) check_eq("b2b_period", 64'(cyc - last), 64'd6);
                last = cyc;
                got++;
            end
            if (rdy4 && v4) pend = 1'b1;
        end
        check_eq("b2b_count", 64'(got), 64'd4);
        tick();
        ordy4 = 1'b0;
        v4 = 1'b0;

        // Random regression, NLIMBS = 4.
        for (int i = 0; i < 1500; i++) begin
            ra = rnd64(); rb = rnd64();
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            start4(ra, rb, rc, rs);
            wait4(n);
            check_eq("rand4_latency", 64'(n), 64'd5);
            drain4($urandom_range(0, 3), ref_model(ra, rb, rc, rs, 64), "rand4");
        end

        // Random regression, NLIMBS = 2.
        for (int i = 0; i < 1500; i++) begin
            ra = rnd64(); rb = rnd64();
            run2(ra[31:0], rb[31:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
